// File: rtl/index_table_ctrl_pkg.sv
// Shared definitions for the index-table controller: FSM state encoding and
// the fixed drain length that covers the memory read latency plus the
// two-stage index-table datapath.
package index_table_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // 1 cycle of mask memory latency + 2 cycles of datapath pipeline
  localparam int DRAIN_CYCLES = 3;

endpackage

// File: rtl/index_table_ctrl.sv
// Index-table controller. Streams mask words out of the mask memory in
// order, forwards a CE/word-index pair aligned with the read data to the
// index-table datapath, and turns the datapath's delayed CE into one index
// table write per word pair (written on the odd word of each pair).
// Optional build macro: INDEX_TABLE_CTRL_PERF_EN adds the stall_cycles
// output counting stalled issue cycles of the current job.
module index_table_ctrl
  import index_table_ctrl_pkg::*;
#(
  parameter int MEM_BW           = 128,
  parameter int ADDR_WIDTH_MASKS = 11,
  parameter int ADDR_WIDTH_ACT   = 14
) (
  input  logic                        clk,
  input  logic                        arst_n_in,
  input  logic                        start,
  input  logic [ADDR_WIDTH_MASKS:0]   num_mask_words,
  input  logic                        stall,
  output logic                        mask_rd_en,
  output logic [ADDR_WIDTH_MASKS-1:0] mask_rd_addr,
  output logic                        idx_CE,
  output logic [31:0]                 idx_masks_transferred,
  input  logic                        delayed_CE,
  input  logic [ADDR_WIDTH_MASKS-1:0] delayed_masks_transferred,
  input  logic [31:0]                 activation_rows_total,
  output logic                        idx_tbl_we,
  output logic [ADDR_WIDTH_MASKS-1:0] idx_tbl_addr,
  output logic [ADDR_WIDTH_ACT-1:0]   idx_tbl_wdata,
`ifdef INDEX_TABLE_CTRL_PERF_EN
  output logic [31:0]                 stall_cycles,
`endif
  output logic                        busy,
  output logic                        done,
  output logic                        err_odd
);

  state_t                      r_state;
  state_t                      w_state_next;
  logic [ADDR_WIDTH_MASKS:0]   r_k;
  logic [ADDR_WIDTH_MASKS:0]   w_k_next;
  logic [ADDR_WIDTH_MASKS:0]   r_n;
  logic [1:0]                  r_drain_cnt;
  logic [1:0]                  w_drain_next;
  logic                        w_accept;
  logic                        w_rd_en;
  logic                        r_idx_ce;
  logic [ADDR_WIDTH_MASKS-1:0] r_idx_mt;
  logic                        r_err_odd;

  // Upper row-total bits are intentionally dropped by the table entry width.
  logic w_unused_row_bits;
  assign w_unused_row_bits = ^activation_rows_total[31:ADDR_WIDTH_ACT];

  // Next-state, issue strobe and counter updates.
  always_comb begin
    w_state_next = r_state;
    w_k_next     = r_k;
    w_drain_next = r_drain_cnt;
    w_accept     = 1'b0;
    w_rd_en      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_k_next     = '0;
          w_drain_next = '0;
          w_state_next = (num_mask_words == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (!stall) begin
          w_rd_en  = 1'b1;
          w_k_next = r_k + 1'b1;
          if (r_k == r_n - 1'b1) begin
            w_state_next = DRAIN;
            w_drain_next = '0;
          end
        end
      end
      DRAIN: begin
        if (r_drain_cnt == 2'(DRAIN_CYCLES - 1)) begin
          w_state_next = DONE;
        end else begin
          w_drain_next = r_drain_cnt + 1'b1;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State, issue counter and job length registers.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_n         <= '0;
      r_drain_cnt <= '0;
      r_err_odd   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_k         <= w_k_next;
      r_drain_cnt <= w_drain_next;
      if (w_accept) begin
        r_n       <= num_mask_words;
        r_err_odd <= num_mask_words[0];
      end
    end
  end

  // CE/word index delayed by one cycle to line up with mask read data.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_idx_ce <= 1'b0;
      r_idx_mt <= '0;
    end else begin
      r_idx_ce <= w_rd_en;
      r_idx_mt <= r_k[ADDR_WIDTH_MASKS-1:0];
    end
  end

`ifdef INDEX_TABLE_CTRL_PERF_EN
  logic [31:0] r_stall_cycles;

  // Saturating count of stalled issue cycles, restarted by each accepted job.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_stall_cycles <= '0;
    end else if (w_accept) begin
      r_stall_cycles <= '0;
    end else if (r_state == ISSUE && stall && r_stall_cycles != 32'hFFFF_FFFF) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

  assign mask_rd_en            = w_rd_en;
  assign mask_rd_addr          = r_k[ADDR_WIDTH_MASKS-1:0];
  assign idx_CE                = r_idx_ce;
  assign idx_masks_transferred = 32'(r_idx_mt);

  // One table entry per word pair, committed when the odd word emerges.
  assign idx_tbl_we    = delayed_CE && delayed_masks_transferred[0];
  assign idx_tbl_addr  = delayed_masks_transferred >> 1;
  assign idx_tbl_wdata = activation_rows_total[ADDR_WIDTH_ACT-1:0];

  assign busy    = (r_state != IDLE);
  assign done    = (r_state == DONE);
  assign err_odd = r_err_odd;

endmodule

// File: tb/tb_index_table_ctrl.sv
// Directed bench for index_table_ctrl. A two-stage delay line stands in for
// the index-table datapath; a negedge monitor logs reads, writes and done.
// Define INDEX_TABLE_CTRL_PERF_EN to also exercise the stall counter.
module tb_index_table_ctrl;

  localparam int AWM = 11;
  localparam int AWA = 14;

  logic            clk = 1'b0;
  logic            arst_n_in;
  logic            start;
  logic [AWM:0]    num_mask_words;
  logic            stall;
  logic            mask_rd_en;
  logic [AWM-1:0]  mask_rd_addr;
  logic            idx_CE;
  logic [31:0]     idx_masks_transferred;
  logic            delayed_CE;
  logic [AWM-1:0]  delayed_masks_transferred;
  logic [31:0]     activation_rows_total;
  logic            idx_tbl_we;
  logic [AWM-1:0]  idx_tbl_addr;
  logic [AWA-1:0]  idx_tbl_wdata;
  logic            busy;
  logic            done;
  logic            err_odd;
`ifdef INDEX_TABLE_CTRL_PERF_EN
  logic [31:0]     stall_cycles;
`endif

  index_table_ctrl #(.MEM_BW(128), .ADDR_WIDTH_MASKS(AWM), .ADDR_WIDTH_ACT(AWA)) dut (
    .clk                       (clk),
    .arst_n_in                 (arst_n_in),
    .start                     (start),
    .num_mask_words            (num_mask_words),
    .stall                     (stall),
    .mask_rd_en                (mask_rd_en),
    .mask_rd_addr              (mask_rd_addr),
    .idx_CE                    (idx_CE),
    .idx_masks_transferred     (idx_masks_transferred),
    .delayed_CE                (delayed_CE),
    .delayed_masks_transferred (delayed_masks_transferred),
    .activation_rows_total     (activation_rows_total),
    .idx_tbl_we                (idx_tbl_we),
    .idx_tbl_addr              (idx_tbl_addr),
    .idx_tbl_wdata             (idx_tbl_wdata),
`ifdef INDEX_TABLE_CTRL_PERF_EN
    .stall_cycles              (stall_cycles),
`endif
    .busy                      (busy),
    .done                      (done),
    .err_odd                   (err_odd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath stand-in: CE and word index delayed by two cycles.
  logic           d1_ce, d2_ce;
  logic [AWM-1:0] d1_mt, d2_mt;
  always @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      d1_ce <= 1'b0; d2_ce <= 1'b0; d1_mt <= '0; d2_mt <= '0;
    end else begin
      d1_ce <= idx_CE;       d2_ce <= d1_ce;
      d1_mt <= idx_masks_transferred[AWM-1:0]; d2_mt <= d1_mt;
    end
  end
  assign delayed_CE                = d2_ce;
  assign delayed_masks_transferred = d2_mt;

  // Event logs, only ever appended to by the monitor.
  int rd_addr_q[$];
  int rd_cyc_q[$];
  int wr_addr_q[$];
  int wr_data_q[$];
  int done_q[$];

  always @(negedge clk) begin
    if (mask_rd_en) begin
      rd_addr_q.push_back(int'(mask_rd_addr));
      rd_cyc_q.push_back(cyc);
    end
    if (idx_tbl_we) begin
      wr_addr_q.push_back(int'(idx_tbl_addr));
      wr_data_q.push_back(int'(idx_tbl_wdata));
    end
    if (done) done_q.push_back(cyc);
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  int m, rd_b, wr_b, dn_b;

  // Launches a job in the current cycle, optionally re-pulses start mid-job,
  // drives stall from a per-cycle mask and waits (bounded) for done.
  task automatic run_job(input int n, input logic [63:0] stall_mask,
                         input int restart_off, input int restart_n);
    bit seen;
    m    = cyc;
    rd_b = rd_addr_q.size();
    wr_b = wr_addr_q.size();
    dn_b = done_q.size();
    start          = 1'b1;
    num_mask_words = (AWM+1)'(n);
    stall          = 1'b0;
    seen           = 1'b0;
    for (int off = 1; off < 60 && !seen; off++) begin
      @(posedge clk); #1;
      start = (off == restart_off);
      if (off == restart_off) num_mask_words = (AWM+1)'(restart_n);
      stall = stall_mask[off];
      if (done_q.size() > dn_b) seen = 1'b1;
    end
    start = 1'b0;
    stall = 1'b0;
    check("done_within_budget", 32'(seen), 32'd1);
    repeat (4) begin @(posedge clk); #1; end
  endtask

  initial begin
    arst_n_in             = 1'b0;
    start                 = 1'b0;
    num_mask_words        = '0;
    stall                 = 1'b0;
    activation_rows_total = 32'hFFFF_5ABC;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_en",  32'(mask_rd_en), 32'd0);
    check("rst_idx_ce", 32'(idx_CE), 32'd0);
    check("rst_idx_mt", idx_masks_transferred, 32'd0);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_done",   32'(done), 32'd0);
    check("rst_err",    32'(err_odd), 32'd0);
    arst_n_in = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // N=4, no stall: reads 0..3 back to back, writes at 0 and 1, done at +8
    run_job(4, 64'd0, -1, 0);
    check("n4_reads", 32'(rd_addr_q.size() - rd_b), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("n4_addr%0d", i), 32'(rd_addr_q[rd_b+i]), 32'(i));
      check($sformatf("n4_cyc%0d", i), 32'(rd_cyc_q[rd_b+i] - m), 32'(i + 1));
    end
    check("n4_writes", 32'(wr_addr_q.size() - wr_b), 32'd2);
    check("n4_waddr0", 32'(wr_addr_q[wr_b]), 32'd0);
    check("n4_waddr1", 32'(wr_addr_q[wr_b+1]), 32'd1);
    check("n4_wdata",  32'(wr_data_q[wr_b]), 32'h1ABC);
    check("n4_done_lat", 32'(done_q[dn_b] - m), 32'd8);
    check("n4_done_pulses", 32'(done_q.size() - dn_b), 32'd1);
    check("n4_err", 32'(err_odd), 32'd0);
    check("n4_busy_after", 32'(busy), 32'd0);

    // N=4, stall in the two cycles after the first read
    activation_rows_total = 32'h0001_2345;
    run_job(4, 64'b1100, -1, 0);
    check("st_reads", 32'(rd_addr_q.size() - rd_b), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("st_addr%0d", i), 32'(rd_addr_q[rd_b+i]), 32'(i));
    check("st_cyc1", 32'(rd_cyc_q[rd_b+1] - m), 32'd4);
    check("st_writes", 32'(wr_addr_q.size() - wr_b), 32'd2);
    check("st_wdata", 32'(wr_data_q[wr_b+1]), 32'h2345);
    check("st_done_lat", 32'(done_q[dn_b] - m), 32'd10);

    // N=0: straight to DONE, no traffic
    run_job(0, 64'd0, -1, 0);
    check("n0_reads",  32'(rd_addr_q.size() - rd_b), 32'd0);
    check("n0_writes", 32'(wr_addr_q.size() - wr_b), 32'd0);
    check("n0_done_lat", 32'(done_q[dn_b] - m), 32'd1);

    // N=3: odd length, last word unwritten
    run_job(3, 64'd0, -1, 0);
    check("n3_err", 32'(err_odd), 32'd1);
    check("n3_reads", 32'(rd_addr_q.size() - rd_b), 32'd3);
    check("n3_writes", 32'(wr_addr_q.size() - wr_b), 32'd1);
    check("n3_waddr0", 32'(wr_addr_q[wr_b]), 32'd0);
    check("n3_done_lat", 32'(done_q[dn_b] - m), 32'd7);

    // N=4 with a start(N=5) pulse while busy: must be ignored
    run_job(4, 64'd0, 2, 5);
    check("rs_reads", 32'(rd_addr_q.size() - rd_b), 32'd4);
    check("rs_done_lat", 32'(done_q[dn_b] - m), 32'd8);
    check("rs_done_pulses", 32'(done_q.size() - dn_b), 32'd1);
    check("rs_err", 32'(err_odd), 32'd0);

`ifdef INDEX_TABLE_CTRL_PERF_EN
    // five stalled issue cycles
    run_job(4, 64'b111_1100, -1, 0);
    check("pf_stall_cycles", stall_cycles, 32'd5);
    check("pf_done_lat", 32'(done_q[dn_b] - m), 32'd13);
`endif

    // Reset in the middle of ISSUE
    start = 1'b1;
    num_mask_words = (AWM+1)'(9);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_err", 32'(err_odd), 32'd1);
    check("mid_rd_en", 32'(mask_rd_en), 32'd1);
    #1;
    arst_n_in = 1'b0;
    #1;
    check("ar_rd_en",  32'(mask_rd_en), 32'd0);
    check("ar_busy",   32'(busy), 32'd0);
    check("ar_idx_ce", 32'(idx_CE), 32'd0);
    check("ar_idx_mt", idx_masks_transferred, 32'd0);
    check("ar_err",    32'(err_odd), 32'd0);
    check("ar_done",   32'(done), 32'd0);
    @(posedge clk); #1;
    arst_n_in = 1'b1;
    rd_b = rd_addr_q.size();
    dn_b = done_q.size();
    repeat (8) begin @(posedge clk); #1; end
    check("ar_no_reads", 32'(rd_addr_q.size() - rd_b), 32'd0);
    check("ar_no_done",  32'(done_q.size() - dn_b), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/index_table_ctrl.md
INDEX_TABLE_CTRL -- requirements
Module: index_table_ctrl

Interface
REQ-001 Parameter MEM_BW, default 128, mask word width in bits.
REQ-002 Parameter ADDR_WIDTH_MASKS, default 11, mask memory and index table address width.
REQ-003 Parameter ADDR_WIDTH_ACT, default 14, index table entry width (activation row pointer).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 arst_n_in  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle job request; sampled only in IDLE.
REQ-007 num_mask_words  in  ADDR_WIDTH_MASKS+1  mask words in the job; sampled with start.
REQ-008 stall  in  1  mask memory not available; blocks issue this cycle.
REQ-009 mask_rd_en  out  1  mask memory read strobe.
REQ-010 mask_rd_addr  out  ADDR_WIDTH_MASKS  mask memory read address.
REQ-011 idx_CE  out  1  CE to index-table datapath, aligned with mask read data.
REQ-012 idx_masks_transferred  out  32  word index presented with idx_CE.
REQ-013 delayed_CE  in  1  datapath CE, 2 cycles after idx_CE.
REQ-014 delayed_masks_transferred  in  ADDR_WIDTH_MASKS  datapath word index, 2 cycles after idx_CE.
REQ-015 activation_rows_total  in  32  datapath running row total.
REQ-016 idx_tbl_we, idx_tbl_addr (ADDR_WIDTH_MASKS), idx_tbl_wdata (ADDR_WIDTH_ACT)  out  index table write port.
REQ-017 busy  out  1  job active; done  out  1  one-cycle completion pulse; err_odd  out  1  sticky odd-length flag.

Function
REQ-018 FSM states IDLE, ISSUE, DRAIN, DONE; IDLE->ISSUE on start with num_mask_words>0.
REQ-019 start with num_mask_words==0: IDLE->DONE, no reads, no writes.
REQ-020 start while busy is ignored; num_mask_words is latched only on accepted start.
REQ-021 ISSUE: per cycle with stall==0, mask_rd_en=1, mask_rd_addr=issue count k (0..N-1), k increments; stall==1 holds k, mask_rd_en=0.
REQ-022 idx_CE and idx_masks_transferred = registered copy of mask_rd_en and k (one cycle, matching memory read latency).
REQ-023 ISSUE->DRAIN in the cycle after read N-1 issues; DRAIN lasts exactly 3 cycles (1 memory + 2 datapath), independent of stall.
REQ-024 idx_tbl_we = delayed_CE && delayed_masks_transferred[0]==1, any state.
REQ-025 idx_tbl_addr = delayed_masks_transferred>>1; idx_tbl_wdata = activation_rows_total[ADDR_WIDTH_ACT-1:0] (truncate).
REQ-026 Entry written for word pair (2j,2j+1) at address j; one write per pair.
REQ-027 DRAIN->DONE; DONE asserts done for one cycle, then ->IDLE; busy=1 in ISSUE, DRAIN, DONE.
REQ-028 Odd num_mask_words: job runs fully, last word gets no write, err_odd set at accept; cleared by next accepted start or reset.
REQ-029 Row total is cumulative across jobs (datapath second accumulator clears only at reset); controller does not rebase it.

Reset
REQ-030 On arst_n_in low: FSM=IDLE, k=0, mask_rd_en=0, idx_CE=0, idx_masks_transferred=0, busy=0, done=0, err_odd=0.
REQ-031 Reset mid-job aborts immediately; no further reads or controller-generated outputs until next start.

Configuration
REQ-032 Macro INDEX_TABLE_CTRL_PERF_EN defined: adds output stall_cycles (32), counting stall==1 cycles in ISSUE, cleared on accepted start, saturating at 2^32-1.
REQ-033 Macro undefined: port and counter absent; all other behaviour identical.

Structure
REQ-034 Shared package holds FSM state enum (IDLE, ISSUE, DRAIN, DONE) and constant DRAIN_CYCLES=3.
REQ-035 No sub-module; single flat controller, index-table datapath instantiated alongside by the parent.

Verification
REQ-036 start, N=4, stall=0 -> addrs 0..3 on 4 consecutive cycles; writes at addr 0,1; done 8 cycles after start.
REQ-037 N=4, stall high 2 cycles after first read -> addrs 0,1,2,3 with 2-cycle gap, no duplicates; done delayed by 2.
REQ-038 N=0 -> done next cycle+1, mask_rd_en and idx_tbl_we never high.
REQ-039 N=3 -> err_odd=1, 3 reads, 1 write at addr 0, done pulses.
REQ-040 start during busy -> ignored, num_mask_words change has no effect; arst_n_in low mid-ISSUE -> outputs reset values same cycle.
REQ-041 PERF_EN build, N=4 with 5 stall cycles -> stall_cycles=5 at done.
